// File: rtl/calc1_port_responder.sv
// calc1 single-port responder: two-cycle command/operand request, response LATENCY+1 edges after the command edge.
// One request per two cycles; fixed-depth result pipeline never stalls and has no backpressure.
module calc1_port_responder #(
    parameter int LATENCY = 3,
    parameter int CNT_W   = 16
) (
    input  logic             c_clk,
    input  logic             reset_n,
    input  logic [3:0]       req_cmd_in,
    input  logic [31:0]      req_data_in,
    output logic [1:0]       out_resp,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic [CNT_W-1:0] req_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        OPND2 = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic        launch;
    logic [3:0]  cmd_q;
    logic [31:0] op1_q;
    logic [32:0] sum;
    logic [1:0]  res_resp;
    logic [31:0] res_data;
    logic [1:0]  pipe_resp [LATENCY];
    logic [31:0] pipe_data [LATENCY];

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cmd_q <= 4'd0;
            op1_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_cmd_in != 4'd0) begin
                cmd_q <= req_cmd_in;
                op1_q <= req_data_in;
            end
        end
    end

    // Command is ignored in OPND2; invalid codes still consume the operand cycle.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (req_cmd_in != 4'd0) state_nxt = OPND2;
            end
            OPND2: begin
                state_nxt = IDLE;
                launch    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == OPND2);

    // Operand 2 is consumed straight off the bus on the launch edge.
    always_comb begin
        sum      = {1'b0, op1_q} + {1'b0, req_data_in};
        res_resp = RESP_ERR;
        res_data = 32'd0;
        case (cmd_q)
            4'd1: begin
                if (!sum[32]) begin
                    res_resp = RESP_OK;
                    res_data = sum[31:0];
                end
            end
            4'd2: begin
                if (req_data_in <= op1_q) begin
                    res_resp = RESP_OK;
                    res_data = op1_q - req_data_in;
                end
            end
            4'd5: begin
                res_resp = RESP_OK;
                res_data = op1_q << req_data_in[4:0];
            end
            4'd6: begin
                res_resp = RESP_OK;
                res_data = op1_q >> req_data_in[4:0];
            end
            default: begin
                res_resp = RESP_ERR;
                res_data = 32'd0;
            end
        endcase
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_resp[i] <= RESP_NONE;
                pipe_data[i] <= 32'd0;
            end
        end else begin
            pipe_resp[0] <= launch ? res_resp : RESP_NONE;
            pipe_data[0] <= launch ? res_data : 32'd0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_resp[i] <= pipe_resp[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // A nonzero resp in the last stage marks a response landing on this edge.
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_resp  <= RESP_NONE;
            out_data  <= 32'd0;
            req_count <= '0;
            err_count <= '0;
        end else begin
            out_resp <= pipe_resp[LATENCY-1];
            out_data <= pipe_data[LATENCY-1];
            if (pipe_resp[LATENCY-1] != RESP_NONE && req_count != '1)
                req_count <= req_count + CNT_W'(1);
            if (pipe_resp[LATENCY-1] == RESP_ERR && err_count != '1)
                err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed bench for calc1_port_responder with a cycle-stamped response scoreboard.
module tb_calc1_port_responder;

    localparam int LAT  = 3;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          c_clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [3:0]    req_cmd_in = 4'd0;
    logic [31:0]   req_data_in = 32'd0;
    logic [1:0]    out_resp;
    logic [31:0]   out_data;
    logic          busy;
    logic [CW-1:0] req_count;
    logic [CW-1:0] err_count;

    typedef struct {
        int          due;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_req = 0;
    int   exp_err = 0;

    calc1_port_responder #(.LATENCY(LAT), .CNT_W(CW)) dut (
        .c_clk       (c_clk),
        .reset_n     (reset_n),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .busy        (busy),
        .req_count   (req_count),
        .err_count   (err_count)
    );

    always #5 c_clk = ~c_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Every sampled cycle either carries the scheduled response or reads 0/0.
    task automatic monitor();
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e = sb.pop_front();
            chk("resp", 32'(out_resp), 32'(e.resp));
            chk("data", out_data, e.data);
            if (exp_req < CMAX) exp_req++;
            if (e.resp == 2'd2 && exp_err < CMAX) exp_err++;
        end else begin
            chk("idle_resp", 32'(out_resp), 32'd0);
            chk("idle_data", out_data, 32'd0);
        end
        chk("req_count", 32'(req_count), 32'(exp_req));
        chk("err_count", 32'(err_count), 32'(exp_err));
    endtask

    task automatic tick();
        @(posedge c_clk);
        cyc++;
        #1;
        monitor();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                        input logic [3:0] cmd2, input logic [1:0] resp, input logic [31:0] data);
        req_cmd_in  = cmd;
        req_data_in = op1;
        tick();
        chk("busy_rise", 32'(busy), 32'd1);
        req_cmd_in  = cmd2;
        req_data_in = op2;
        tick();
        chk("busy_fall", 32'(busy), 32'd0);
        sb.push_back('{cyc + LAT, resp, data});
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
    endtask

    // Asserted mid-cycle so the asynchronous clear is visible before any edge.
    task automatic do_reset();
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        reset_n     = 1'b0;
        #1;
        sb.delete();
        exp_req = 0;
        exp_err = 0;
        chk("rst_resp", 32'(out_resp), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(req_count), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();

        send(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 4'd0, 2'd1, 32'h0200_0000);
        send(4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 4'd0, 2'd1, 32'h3FFF_FFFE);
        send(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 2'd2, 32'd0);
        idle(LAT + 2);
        chk("err_after_ovf", 32'(err_count), 32'd1);

        for (int i = 0; i < 32; i++) begin
            logic [31:0] x;
            x = 32'd1 << i;
            send(4'd1, x, 32'd0, 4'(i), 2'd1, x);
        end
        idle(LAT + 2);

        send(4'd2, 32'd1,  32'd15, 4'd0, 2'd2, 32'd0);
        send(4'd2, 32'd15, 32'd1,  4'd0, 2'd1, 32'd14);
        send(4'd2, 32'd5,  32'd5,  4'd0, 2'd1, 32'd0);
        send(4'd5, 32'h0000_0001, 32'h0000_0021, 4'd0, 2'd1, 32'h0000_0002);
        send(4'd5, 32'h8000_0000, 32'd1,  4'd0, 2'd1, 32'd0);
        send(4'd6, 32'h8000_0000, 32'd31, 4'd0, 2'd1, 32'h0000_0001);
        idle(LAT + 2);

        do_reset();
        send(4'd3,  32'd7, 32'd9, 4'd1, 2'd2, 32'd0);
        send(4'd4,  32'd7, 32'd9, 4'd1, 2'd2, 32'd0);
        send(4'd7,  32'd7, 32'd9, 4'd1, 2'd2, 32'd0);
        send(4'd15, 32'd7, 32'd9, 4'd1, 2'd2, 32'd0);
        idle(LAT + 2);
        chk("inv_req_count", 32'(req_count), 32'd4);
        chk("inv_err_count", 32'(err_count), 32'd4);

        send(4'd1, 32'd100, 32'd23, 4'd0, 2'd1, 32'd123);
        send(4'd6, 32'hF000_0000, 32'd4, 4'd0, 2'd1, 32'h0F00_0000);
        send(4'd2, 32'd3, 32'd4, 4'd0, 2'd2, 32'd0);
        idle(LAT + 2);

        send(4'd1, 32'd10, 32'd20, 4'd0, 2'd1, 32'd30);
        send(4'd2, 32'd9,  32'd4,  4'd0, 2'd1, 32'd5);
        req_cmd_in  = 4'd5;
        req_data_in = 32'd3;
        tick();
        chk("busy_pre_rst", 32'(busy), 32'd1);
        do_reset();
        idle(LAT + 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
